logic_axi4_stream_arbiter: RTL and testbench

LOGIC_AXI4_STREAM_ARBITER -- requirements
Module: logic_axi4_stream_arbiter

---
 rtl/logic_axi4_stream_arbiter_if.sv | 45 ++++
 rtl/logic_axi4_stream_arbiter.sv | 113 +++++++++++
 tb/tb_logic_axi4_stream_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_axi4_stream_arbiter_if.sv
// AXI4-Stream N:1 arbiter bus: packed per-requester rx streams and one muxed tx stream.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface logic_axi4_stream_arbiter_if #(
  parameter int unsigned INPUTS      = 2,
  parameter int unsigned TDATA_BYTES = 1,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1
);
  localparam int unsigned DATA_W = 8 * TDATA_BYTES;

  logic [INPUTS-1:0]             rx_tvalid;
  logic [INPUTS-1:0]             rx_tready;
  logic [INPUTS-1:0]             rx_tlast;
  logic [INPUTS*DATA_W-1:0]      rx_tdata;
  logic [INPUTS*TDATA_BYTES-1:0] rx_tkeep;
  logic [INPUTS*TDATA_BYTES-1:0] rx_tstrb;
  logic [INPUTS*TUSER_WIDTH-1:0] rx_tuser;
  logic [INPUTS*TDEST_WIDTH-1:0] rx_tdest;
  logic [INPUTS*TID_WIDTH-1:0]   rx_tid;

  logic                   tx_tvalid;
  logic                   tx_tready;
  logic                   tx_tlast;
  logic [DATA_W-1:0]      tx_tdata;
  logic [TDATA_BYTES-1:0] tx_tkeep;
  logic [TDATA_BYTES-1:0] tx_tstrb;
  logic [TUSER_WIDTH-1:0] tx_tuser;
  logic [TDEST_WIDTH-1:0] tx_tdest;
  logic [TID_WIDTH-1:0]   tx_tid;

  modport master (
    input  rx_tvalid, rx_tlast, rx_tdata, rx_tkeep, rx_tstrb, rx_tuser, rx_tdest, rx_tid,
    output rx_tready,
    output tx_tvalid, tx_tlast, tx_tdata, tx_tkeep, tx_tstrb, tx_tuser, tx_tdest, tx_tid,
    input  tx_tready
  );

  modport slave (
    output rx_tvalid, rx_tlast, rx_tdata, rx_tkeep, rx_tstrb, rx_tuser, rx_tdest, rx_tid,
    input  rx_tready,
    input  tx_tvalid, tx_tlast, tx_tdata, tx_tkeep, tx_tstrb, tx_tuser, tx_tdest, tx_tid,
    output tx_tready
  );
endinterface

// File: rtl/logic_axi4_stream_arbiter.sv
// Packet-locked round-robin arbiter merging INPUTS AXI4-Stream requesters onto one stream.
// Ownership is granted in an idle cycle and held until the owner's last beat transfers.
module logic_axi4_stream_arbiter #(
  parameter int unsigned INPUTS      = 2,
  parameter int unsigned TDATA_BYTES = 1,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1,
  parameter bit          USE_TLAST   = 1'b1,
  parameter bit          USE_TKEEP   = 1'b1,
  parameter bit          USE_TSTRB   = 1'b1,
  localparam int unsigned GRANT_W    = $clog2(INPUTS)
) (
  input  logic                   aclk,
  input  logic                   reset,
  logic_axi4_stream_arbiter_if.master bus,
  output logic [GRANT_W-1:0]     grant,
  output logic                   busy
);
  localparam int unsigned DATA_W = 8 * TDATA_BYTES;
  localparam int unsigned SCAN_W = GRANT_W + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [GRANT_W-1:0] ptr, ptr_nxt, grant_nxt;
  logic               cand_found;
  logic [GRANT_W-1:0] cand_idx;
  logic [SCAN_W-1:0]  scan;
  logic               owner_valid, owner_last;

  // First valid requester scanning circularly from ptr; the extra scan bit keeps ptr+k exact.
  always_comb begin : select_c
    cand_found = 1'b0;
    cand_idx   = '0;
    scan       = '0;
    for (int unsigned k = 0; k < INPUTS; k++) begin
      scan = {1'b0, ptr} + SCAN_W'(k);
      if (scan >= SCAN_W'(INPUTS)) scan = scan - SCAN_W'(INPUTS);
      if (!cand_found && bus.rx_tvalid[scan[GRANT_W-1:0]]) begin
        cand_found = 1'b1;
        cand_idx   = scan[GRANT_W-1:0];
      end
    end
  end

  // Combinational data/sideband mux from the owner's slice.
  always_comb begin : mux_c
    owner_valid  = 1'b0;
    owner_last   = 1'b1;
    bus.tx_tdata = '0;
    bus.tx_tkeep = '1;
    bus.tx_tstrb = '1;
    bus.tx_tuser = '0;
    bus.tx_tdest = '0;
    bus.tx_tid   = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      if (grant == GRANT_W'(i)) begin
        owner_valid  = bus.rx_tvalid[i];
        owner_last   = USE_TLAST ? bus.rx_tlast[i] : 1'b1;
        bus.tx_tdata = bus.rx_tdata[i*DATA_W +: DATA_W];
        if (USE_TKEEP) bus.tx_tkeep = bus.rx_tkeep[i*TDATA_BYTES +: TDATA_BYTES];
        if (USE_TSTRB) bus.tx_tstrb = bus.rx_tstrb[i*TDATA_BYTES +: TDATA_BYTES];
        bus.tx_tuser = bus.rx_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
        bus.tx_tdest = bus.rx_tdest[i*TDEST_WIDTH +: TDEST_WIDTH];
        bus.tx_tid   = bus.rx_tid[i*TID_WIDTH +: TID_WIDTH];
      end
    end
    bus.tx_tlast = owner_last;
  end

  // Next-state, grant/ptr update and handshake routing.
  always_comb begin : fsm_c
    state_nxt     = state;
    grant_nxt     = grant;
    ptr_nxt       = ptr;
    bus.tx_tvalid = 1'b0;
    bus.rx_tready = '0;
    case (state)
      IDLE: begin
        if (cand_found) begin
          state_nxt = LOCKED;
          grant_nxt = cand_idx;
        end
      end
      LOCKED: begin
        bus.tx_tvalid = owner_valid;
        for (int unsigned i = 0; i < INPUTS; i++) begin
          if (grant == GRANT_W'(i)) bus.rx_tready[i] = bus.tx_tready;
        end
        if (owner_valid && bus.tx_tready && owner_last) begin
          state_nxt = IDLE;
          ptr_nxt   = (grant == GRANT_W'(INPUTS - 1)) ? '0 : grant + GRANT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin : state_q
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      grant <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      grant <= grant_nxt;
      busy  <= (state_nxt == LOCKED);
    end
  end
endmodule

// File: tb/tb_logic_axi4_stream_arbiter.sv
// Directed bench: a 4-input arbiter with tlast and a 3-input arbiter without tlast/tkeep,
// fed by counting sources whose beats encode requester id and sequence number.
module tb_logic_axi4_stream_arbiter;
  logic aclk = 1'b0;
  logic reset;
  always #5 aclk = ~aclk;

  logic_axi4_stream_arbiter_if #(.INPUTS(4), .TDATA_BYTES(1), .TUSER_WIDTH(4),
                                 .TDEST_WIDTH(4), .TID_WIDTH(4)) b4 ();
  logic_axi4_stream_arbiter_if #(.INPUTS(3), .TDATA_BYTES(2), .TUSER_WIDTH(2),
                                 .TDEST_WIDTH(2), .TID_WIDTH(2)) b3 ();

  logic [1:0] grant4, grant3;
  logic       busy4, busy3;

  logic_axi4_stream_arbiter #(.INPUTS(4), .TDATA_BYTES(1), .TUSER_WIDTH(4), .TDEST_WIDTH(4),
                              .TID_WIDTH(4), .USE_TLAST(1'b1), .USE_TKEEP(1'b1),
                              .USE_TSTRB(1'b1)) dut4 (
    .aclk(aclk), .reset(reset), .bus(b4), .grant(grant4), .busy(busy4));

  logic_axi4_stream_arbiter #(.INPUTS(3), .TDATA_BYTES(2), .TUSER_WIDTH(2), .TDEST_WIDTH(2),
                              .TID_WIDTH(2), .USE_TLAST(1'b0), .USE_TKEEP(1'b0),
                              .USE_TSTRB(1'b1)) dut3 (
    .aclk(aclk), .reset(reset), .bus(b3), .grant(grant3), .busy(busy3));

  int checks = 0;
  int errors = 0;
  int seq4[4];
  int seq3[3];
  logic [3:0] en4;
  logic [2:0] en3;
  int plen4;
  logic tready4, tready3;
  int q4[$];
  int q3[$];
  logic [31:0] hs_log4;

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      b4.rx_tvalid[i]         = en4[i];
      b4.rx_tdata[i*8 +: 8]   = {2'(i), 6'(seq4[i])};
      b4.rx_tlast[i]          = ((seq4[i] % plen4) == plen4 - 1);
      b4.rx_tkeep[i]          = 1'(seq4[i]);
      b4.rx_tstrb[i]          = ~1'(seq4[i]);
      b4.rx_tuser[i*4 +: 4]   = 4'(i + seq4[i]);
      b4.rx_tdest[i*4 +: 4]   = 4'(i);
      b4.rx_tid[i*4 +: 4]     = 4'(15 - i);
    end
    b4.tx_tready = tready4;
    for (int i = 0; i < 3; i++) begin
      b3.rx_tvalid[i]         = en3[i];
      b3.rx_tdata[i*16 +: 16] = {8'(i), 8'(seq3[i])};
      b3.rx_tlast[i]          = 1'b0;
      b3.rx_tkeep[i*2 +: 2]   = 2'b01;
      b3.rx_tstrb[i*2 +: 2]   = 2'b10;
      b3.rx_tuser[i*2 +: 2]   = 2'(seq3[i]);
      b3.rx_tdest[i*2 +: 2]   = 2'(i + 1);
      b3.rx_tid[i*2 +: 2]     = 2'(i);
    end
    b3.tx_tready = tready3;
  endtask

  // One clock: scoreboard the handshakes the coming edge commits, then advance the sources.
  task automatic step();
    logic [3:0] h4;
    logic [2:0] h3;
    logic t4, t3, exp_last;
    int src;
    drive();
    @(negedge aclk);
    h4 = b4.rx_tvalid & b4.rx_tready;
    t4 = b4.tx_tvalid & b4.tx_tready;
    h3 = b3.rx_tvalid & b3.rx_tready;
    t3 = b3.tx_tvalid & b3.tx_tready;
    hs_log4 = {hs_log4[30:0], t4};
    checks++;
    if ($countones(h4) != (t4 ? 1 : 0)) begin
      errors++;
      $display("FAIL sb4_handshake: rx_hs=%b tx_hs=%b", h4, t4);
    end
    if (t4) begin
      src = int'(b4.tx_tdata[7:6]);
      exp_last = ((seq4[src] % plen4) == plen4 - 1);
      checks++;
      if (h4[src] !== 1'b1 || b4.tx_tdata[5:0] !== 6'(seq4[src]) ||
          b4.tx_tid !== 4'(15 - src) || b4.tx_tdest !== 4'(src) ||
          b4.tx_tuser !== 4'(src + seq4[src]) || b4.tx_tlast !== exp_last ||
          b4.tx_tkeep !== 1'(seq4[src]) || b4.tx_tstrb !== ~1'(seq4[src])) begin
        errors++;
        $display("FAIL sb4_beat: src=%0d data=%h last=%b tid=%h dest=%h user=%h, required seq=%0d last=%b",
                 src, b4.tx_tdata, b4.tx_tlast, b4.tx_tid, b4.tx_tdest, b4.tx_tuser,
                 seq4[src], exp_last);
      end
      if ((seq4[src] % plen4) == 0) q4.push_back(src);
    end
    checks++;
    if ($countones(h3) != (t3 ? 1 : 0)) begin
      errors++;
      $display("FAIL sb3_handshake: rx_hs=%b tx_hs=%b", h3, t3);
    end
    if (t3) begin
      src = int'(b3.tx_tdata[15:8]);
      checks++;
      if (src > 2) begin
        errors++;
        $display("FAIL sb3_source: got source %0d, required 0..2", src);
      end else if (h3[src] !== 1'b1 || b3.tx_tdata[7:0] !== 8'(seq3[src]) ||
                   b3.tx_tlast !== 1'b1 || b3.tx_tkeep !== 2'b11 || b3.tx_tstrb !== 2'b10 ||
                   b3.tx_tid !== 2'(src) || b3.tx_tdest !== 2'(src + 1) ||
                   b3.tx_tuser !== 2'(seq3[src])) begin
        errors++;
        $display("FAIL sb3_beat: src=%0d data=%h last=%b keep=%b strb=%b, required seq=%0d last=1 keep=11 strb=10",
                 src, b3.tx_tdata, b3.tx_tlast, b3.tx_tkeep, b3.tx_tstrb, seq3[src]);
      end
      if (src <= 2) q3.push_back(src);
    end
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) if (h4[i]) seq4[i]++;
    for (int i = 0; i < 3; i++) if (h3[i]) seq3[i]++;
    drive();
    #1;
  endtask

  task automatic clear_seq();
    for (int i = 0; i < 4; i++) seq4[i] = 0;
    for (int i = 0; i < 3; i++) seq3[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en4 = '0;
    en3 = '0;
    tready4 = 1'b1;
    tready3 = 1'b1;
    step();
    step();
    clear_seq();
    reset = 1'b0;
    drive();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en4 = 4'hF;
    en3 = 3'h7;
    step();
    step();
    checks++;
    if (busy4 !== 1'b0 || grant4 !== 2'd0 || b4.tx_tvalid !== 1'b0 || b4.rx_tready !== 4'h0) begin
      errors++;
      $display("FAIL reset4: busy=%b grant=%0d tvalid=%b rx_tready=%b, required 0/0/0/0000",
               busy4, grant4, b4.tx_tvalid, b4.rx_tready);
    end
    checks++;
    if (busy3 !== 1'b0 || grant3 !== 2'd0 || b3.tx_tvalid !== 1'b0 || b3.rx_tready !== 3'h0) begin
      errors++;
      $display("FAIL reset3: busy=%b grant=%0d tvalid=%b rx_tready=%b, required 0/0/0/000",
               busy3, grant3, b3.tx_tvalid, b3.rx_tready);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [14:0] exp_hs;
    int exp_q[5] = '{0, 1, 2, 3, 0};
    do_reset();
    plen4 = 2;
    en4 = 4'hF;
    hs_log4 = '0;
    q4.delete();
    repeat (15) step();
    for (int k = 0; k < 15; k++) exp_hs[14-k] = ((k % 3) != 0);
    checks++;
    if (hs_log4[14:0] !== exp_hs) begin
      errors++;
      $display("FAIL rr_beat_pattern: got %b, required %b", hs_log4[14:0], exp_hs);
    end
    checks++;
    if (q4.size() != 5) begin
      errors++;
      $display("FAIL rr_packet_count: got %0d, required 5", q4.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (q4[k] != exp_q[k]) begin
          errors++;
          $display("FAIL rr_grant_seq[%0d]: got %0d, required %0d", k, q4[k], exp_q[k]);
        end
      end
    end
    en4 = '0;
  endtask

  task automatic test_single_requester();
    do_reset();
    plen4 = 2;
    en4 = 4'b0100;
    drive();
    #1;
    checks++;
    if (b4.tx_tvalid !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: tvalid=%b busy=%b, required 0/0", b4.tx_tvalid, busy4);
    end
    step();
    checks++;
    if (busy4 !== 1'b1 || grant4 !== 2'd2) begin
      errors++;
      $display("FAIL single_grant: busy=%b grant=%0d, required 1/2", busy4, grant4);
    end
    step();
    step();
    checks++;
    if (busy4 !== 1'b0) begin
      errors++;
      $display("FAIL single_release: busy=%b, required 0", busy4);
    end
    en4 = 4'b0110;
    step();
    checks++;
    if (grant4 !== 2'd1) begin
      errors++;
      $display("FAIL single_wrap_scan: grant=%0d, required 1", grant4);
    end
    step();
    step();
    step();
    checks++;
    if (grant4 !== 2'd2 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL single_next_owner: grant=%0d busy=%b, required 2/1", grant4, busy4);
    end
    en4 = '0;
  endtask

  task automatic test_hold_ownership();
    do_reset();
    plen4 = 4;
    en4 = 4'b0010;
    step();
    checks++;
    if (grant4 !== 2'd1) begin
      errors++;
      $display("FAIL hold_initial_grant: grant=%0d, required 1", grant4);
    end
    for (int c = 0; c < 9; c++) begin
      tready4 = ((c % 2) == 0);
      en4 = {2'b00, (c != 2), 1'b1};
      step();
      checks++;
      if (b4.rx_tready[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold_rx_tready0[%0d]: got %b, required 0", c, b4.rx_tready[0]);
      end
      checks++;
      if (c < 8 && (grant4 !== 2'd1 || busy4 !== 1'b1)) begin
        errors++;
        $display("FAIL hold_owner[%0d]: grant=%0d busy=%b, required 1/1", c, grant4, busy4);
      end else if (c == 8 && busy4 !== 1'b0) begin
        errors++;
        $display("FAIL hold_release: busy=%b, required 0", busy4);
      end
    end
    tready4 = 1'b1;
    step();
    checks++;
    if (grant4 !== 2'd0 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL hold_next_grant: grant=%0d busy=%b, required 0/1", grant4, busy4);
    end
    en4 = '0;
  endtask

  task automatic test_no_tlast();
    int exp_q[4] = '{0, 1, 2, 0};
    do_reset();
    en3 = 3'b111;
    q3.delete();
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (grant3 > 2'd2) begin
        errors++;
        $display("FAIL notlast_grant_range[%0d]: grant=%0d, required <3", c, grant3);
      end
    end
    checks++;
    if (q3.size() != 4) begin
      errors++;
      $display("FAIL notlast_beat_count: got %0d, required 4", q3.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (q3[k] != exp_q[k]) begin
          errors++;
          $display("FAIL notlast_grant_seq[%0d]: got %0d, required %0d", k, q3[k], exp_q[k]);
        end
      end
    end
    en3 = '0;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    plen4 = 4;
    en4 = 4'b1000;
    step();
    checks++;
    if (grant4 !== 2'd3) begin
      errors++;
      $display("FAIL midreset_grant: grant=%0d, required 3", grant4);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if (busy4 !== 1'b0 || b4.tx_tvalid !== 1'b0 || b4.rx_tready !== 4'h0 || grant4 !== 2'd0) begin
      errors++;
      $display("FAIL midreset_abandon: busy=%b tvalid=%b rx_tready=%b grant=%0d, required 0/0/0000/0",
               busy4, b4.tx_tvalid, b4.rx_tready, grant4);
    end
    reset = 1'b0;
    clear_seq();
    en4 = 4'hF;
    step();
    checks++;
    if (grant4 !== 2'd0 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_first_grant: grant=%0d busy=%b, required 0/1", grant4, busy4);
    end
    en4 = '0;
  endtask

  initial begin
    reset = 1'b1;
    en4 = '0;
    en3 = '0;
    plen4 = 2;
    tready4 = 1'b1;
    tready3 = 1'b1;
    hs_log4 = '0;
    clear_seq();
    drive();
    test_reset();
    test_round_robin();
    test_single_requester();
    test_hold_ownership();
    test_no_tlast();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
